// File: rtl/simplez_bus_cpu_pkg.sv
// Shared opcode, EXT sub-opcode and FSM state encodings for the bus-attached Simplez core.
package simplez_bus_cpu_pkg;

  typedef enum logic [2:0] {
    OpSt  = 3'd0,
    OpLd  = 3'd1,
    OpAdd = 3'd2,
    OpBr  = 3'd3,
    OpBz  = 3'd4,
    OpClr = 3'd5,
    OpDec = 3'd6,
    OpExt = 3'd7
  } opcode_e;

  localparam logic [3:0] CoeHalt = 4'hE;
  localparam logic [3:0] CoeWait = 4'hF;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StExec    = 3'd2,
    StMem     = 3'd3,
    StWaiting = 3'd4,
    StHalted  = 3'd5
  } state_e;

  // Instruction/data word: 3 opcode bits on top of an AW-bit operand.
  function automatic int unsigned dw_of(input int unsigned aw);
    return aw + 3;
  endfunction

endpackage

// File: rtl/simplez_bus_cpu_if.sv
// Generic req/ack bus between the Simplez core (master) and memory/peripheral slaves.
interface simplez_bus_cpu_if
  import simplez_bus_cpu_pkg::*;
#(
  parameter int unsigned AW = 9
) ();
  localparam int unsigned DW = dw_of(AW);

  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );

endinterface

// File: rtl/simplez_wait_timer.sv
// Down-counter for the WAIT instruction: start loads WAIT_DELAY, done pulses in the last cycle.
module simplez_wait_timer #(
  parameter int unsigned WAIT_DELAY = 2400000
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic done
);
  localparam int unsigned CW = $clog2(WAIT_DELAY + 1);
  localparam logic [CW-1:0] LoadVal = CW'(WAIT_DELAY);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= LoadVal;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Counter visits WAIT_DELAY..1, so the caller spends exactly WAIT_DELAY cycles waiting.
  assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/simplez_bus_cpu.sv
// Simplez core with the data/program memory on an external req/ack bus, single-step and debug taps.
module simplez_bus_cpu
  import simplez_bus_cpu_pkg::*;
#(
  parameter int unsigned   AW         = 9,
  parameter logic [AW-1:0] RESET_PC   = '0,
  parameter int unsigned   WAIT_DELAY = 2400000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  step_en,
  simplez_bus_cpu_if.master     bus,
  output logic                  halted,
  output logic [AW-1:0]         dbg_pc,
  output logic [dw_of(AW)-1:0]  dbg_a
);
  localparam int unsigned DW = dw_of(AW);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] ri_q;
  logic [DW-1:0] a_q;
  logic          z_q;
  logic          halted_q;
  logic          req_q;
  logic          we_q;
  logic [AW-1:0] addr_q;

  opcode_e       co;
  logic [3:0]    coe;
  logic [AW-1:0] cd;
  logic [DW-1:0] add_res;
  logic [DW-1:0] dec_res;
  logic          wait_start;
  logic          wait_done;

  assign co      = opcode_e'(ri_q[DW-1 -: 3]);
  assign coe     = ri_q[DW-1 -: 4];
  assign cd      = ri_q[AW-1:0];
  assign add_res = a_q + bus.bus_rdata;
  assign dec_res = a_q - DW'(1);

  assign wait_start = (state_q == StExec) && (co == OpExt) && (coe == CoeWait);

  simplez_wait_timer #(
    .WAIT_DELAY (WAIT_DELAY)
  ) u_wait_timer (
    .clk   (clk),
    .rstn  (rstn),
    .start (wait_start),
    .done  (wait_done)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      ri_q     <= '0;
      a_q      <= '0;
      z_q      <= 1'b0;
      halted_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (step_en) begin
            state_q <= StFetch;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= pc_q;
          end
        end
        StFetch: begin
          if (bus.bus_ack) begin
            ri_q    <= bus.bus_rdata;
            pc_q    <= pc_q + 1'b1;
            req_q   <= 1'b0;
            state_q <= StExec;
          end
        end
        StExec: begin
          state_q <= StIdle;
          case (co)
            OpSt, OpLd, OpAdd: begin
              req_q   <= 1'b1;
              we_q    <= (co == OpSt);
              addr_q  <= cd;
              state_q <= StMem;
            end
            OpBr: pc_q <= cd;
            OpBz: if (z_q) pc_q <= cd;
            OpClr: begin
              a_q <= '0;
              z_q <= 1'b1;
            end
            OpDec: begin
              a_q <= dec_res;
              z_q <= (dec_res == '0);
            end
            OpExt: begin
              if (coe == CoeHalt) begin
                halted_q <= 1'b1;
                state_q  <= StHalted;
              end else if (coe == CoeWait) begin
                state_q <= StWaiting;
              end
            end
          endcase
        end
        StMem: begin
          if (bus.bus_ack) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= StIdle;
            if (co == OpLd) begin
              a_q <= bus.bus_rdata;
              z_q <= (bus.bus_rdata == '0);
            end else if (co == OpAdd) begin
              a_q <= add_res;
              z_q <= (add_res == '0);
            end
          end
        end
        StWaiting: begin
          if (wait_done) state_q <= StIdle;
        end
        StHalted: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = a_q;

  assign halted = halted_q;
  assign dbg_pc = pc_q;
  assign dbg_a  = a_q;

endmodule
